fpf_decoder_38: RTL



---
 rtl/fpf_decoder_38_pkg.sv | 71 +++++++
 rtl/fpf_decoder_38_partial_sum.sv | 22 ++
 rtl/fpf_decoder_38.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fpf_decoder_38_pkg.sv
// Shared constants for the 38-bit FPF decoder.
// Fibonacci weights FNS01..FNS39, the output width FBLEN38 and the internal
// sum width FPF_DEC_SUMLEN are kept as macros. fns_weight() maps a code bit
// index to its weight. Optional build macro: FPF_CHECK_EN (see fpf_decoder_38).
`ifndef FNS_VH
`define FNS_VH
`define FBLEN38        27
`define FPF_DEC_SUMLEN 28
`define FNS01 28'd1
`define FNS02 28'd1
`define FNS03 28'd2
`define FNS04 28'd3
`define FNS05 28'd5
`define FNS06 28'd8
`define FNS07 28'd13
`define FNS08 28'd21
`define FNS09 28'd34
`define FNS10 28'd55
`define FNS11 28'd89
`define FNS12 28'd144
`define FNS13 28'd233
`define FNS14 28'd377
`define FNS15 28'd610
`define FNS16 28'd987
`define FNS17 28'd1597
`define FNS18 28'd2584
`define FNS19 28'd4181
`define FNS20 28'd6765
`define FNS21 28'd10946
`define FNS22 28'd17711
`define FNS23 28'd28657
`define FNS24 28'd46368
`define FNS25 28'd75025
`define FNS26 28'd121393
`define FNS27 28'd196418
`define FNS28 28'd317811
`define FNS29 28'd514229
`define FNS30 28'd832040
`define FNS31 28'd1346269
`define FNS32 28'd2178309
`define FNS33 28'd3524578
`define FNS34 28'd5702887
`define FNS35 28'd9227465
`define FNS36 28'd14930352
`define FNS37 28'd24157817
`define FNS38 28'd39088169
`define FNS39 28'd63245986
`endif

package fpf_decoder_38_pkg;

   // Weight of code bit k: bit 0 -> FNS01, bit k -> FNS(k+1)
   function automatic logic [`FPF_DEC_SUMLEN-1:0] fns_weight(input int k);
      logic [`FPF_DEC_SUMLEN-1:0] w;
      case (k)
         0:  w = `FNS01;   1:  w = `FNS02;   2:  w = `FNS03;   3:  w = `FNS04;
         4:  w = `FNS05;   5:  w = `FNS06;   6:  w = `FNS07;   7:  w = `FNS08;
         8:  w = `FNS09;   9:  w = `FNS10;   10: w = `FNS11;   11: w = `FNS12;
         12: w = `FNS13;   13: w = `FNS14;   14: w = `FNS15;   15: w = `FNS16;
         16: w = `FNS17;   17: w = `FNS18;   18: w = `FNS19;   19: w = `FNS20;
         20: w = `FNS21;   21: w = `FNS22;   22: w = `FNS23;   23: w = `FNS24;
         24: w = `FNS25;   25: w = `FNS26;   26: w = `FNS27;   27: w = `FNS28;
         28: w = `FNS29;   29: w = `FNS30;   30: w = `FNS31;   31: w = `FNS32;
         32: w = `FNS33;   33: w = `FNS34;   34: w = `FNS35;   35: w = `FNS36;
         36: w = `FNS37;   37: w = `FNS38;
         default: w = '0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/fpf_decoder_38_partial_sum.sv
// fpf_partial_sum: weighted Fibonacci sum of one slice of a codeword.
// BASE is the index of slice[0] within the full 38-bit codeword.
module fpf_partial_sum
   import fpf_decoder_38_pkg::*;
#(
   parameter int BASE  = 0,
   parameter int WIDTH = 13
)
(
   input  logic [WIDTH-1:0]           slice,
   output logic [`FPF_DEC_SUMLEN-1:0] sum
);

   // Accumulate the weight of every set bit in the slice
   always_comb begin
      sum = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (slice[i]) sum = sum + fns_weight(BASE + i);
      end
   end

endmodule

// File: rtl/fpf_decoder_38.sv
// fpf_decoder_38: 3-stage pipelined FPF codeword -> binary decoder.
// S1 registers the codeword, S2 registers three slice partial sums, S3
// registers their total into data_out. Define FPF_CHECK_EN to add the
// forbidden-pattern flag fpf_err, carried alongside each word.
module fpf_decoder_38
   import fpf_decoder_38_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic [37:0]         code_in,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [`FBLEN38-1:0] data_out,
   output logic                out_valid,
`ifdef FPF_CHECK_EN
   output logic                fpf_err,
`endif
   input  logic                out_ready
);

   // Handshake: a word crosses a boundary on a cycle where valid & ready are
   // both high. A stage loads when it is empty or its word leaves in the same
   // cycle, so ready ripples combinationally from out_ready back to in_ready.
   logic                       s1_load, s2_load, s3_load;
   logic                       s1_valid_q, s1_valid_d;
   logic [37:0]                s1_code_q, s1_code_d;
   logic [`FPF_DEC_SUMLEN-1:0] ps0, ps1, ps2;
   logic                       s2_valid_q, s2_valid_d;
   logic [`FPF_DEC_SUMLEN-1:0] s2_sum0_q, s2_sum0_d;
   logic [`FPF_DEC_SUMLEN-1:0] s2_sum1_q, s2_sum1_d;
   logic [`FPF_DEC_SUMLEN-1:0] s2_sum2_q, s2_sum2_d;
   logic                       s3_valid_q, s3_valid_d;
   logic [`FBLEN38-1:0]        s3_data_q, s3_data_d;
`ifdef FPF_CHECK_EN
   logic                       code_err;
   logic                       s1_err_q, s1_err_d;
   logic                       s2_err_q, s2_err_d;
   logic                       s3_err_q, s3_err_d;
`endif

   // Per-stage load enables and the upstream ready
   always_comb begin
      s3_load  = !s3_valid_q || out_ready;
      s2_load  = !s2_valid_q || s3_load;
      s1_load  = !s1_valid_q || s2_load;
      in_ready = s1_load;
   end

   fpf_partial_sum #(.BASE(0),  .WIDTH(13)) u_ps_lo  (.slice(s1_code_q[12:0]),  .sum(ps0));
   fpf_partial_sum #(.BASE(13), .WIDTH(13)) u_ps_mid (.slice(s1_code_q[25:13]), .sum(ps1));
   fpf_partial_sum #(.BASE(26), .WIDTH(12)) u_ps_hi  (.slice(s1_code_q[37:26]), .sum(ps2));

`ifdef FPF_CHECK_EN
   // Flag any isolated 1 (010) or isolated 0 (101) inside the codeword
   always_comb begin
      code_err = 1'b0;
      for (int k = 0; k < 36; k++) begin
         if (code_in[k +: 3] == 3'b010 || code_in[k +: 3] == 3'b101) code_err = 1'b1;
      end
   end
`endif

   // Next-state: valid bits follow the load enables, payload only loads on a
   // real upstream word so bubbles never disturb held data
   always_comb begin
      s1_valid_d = s1_load ? in_valid : s1_valid_q;
      s1_code_d  = (s1_load && in_valid) ? code_in : s1_code_q;
      s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
      s2_sum0_d  = (s2_load && s1_valid_q) ? ps0 : s2_sum0_q;
      s2_sum1_d  = (s2_load && s1_valid_q) ? ps1 : s2_sum1_q;
      s2_sum2_d  = (s2_load && s1_valid_q) ? ps2 : s2_sum2_q;
      s3_valid_d = s3_load ? s2_valid_q : s3_valid_q;
      // 28-bit total; only the low FBLEN38 bits reach data_out
      s3_data_d  = (s3_load && s2_valid_q) ?
                   `FBLEN38'(s2_sum0_q + s2_sum1_q + s2_sum2_q) : s3_data_q;
`ifdef FPF_CHECK_EN
      s1_err_d   = (s1_load && in_valid) ? code_err : s1_err_q;
      s2_err_d   = (s2_load && s1_valid_q) ? s1_err_q : s2_err_q;
      s3_err_d   = (s3_load && s2_valid_q) ? s2_err_q : s3_err_q;
`endif
   end

   // Pipeline registers, cleared asynchronously
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_code_q  <= '0;
         s2_valid_q <= 1'b0;
         s2_sum0_q  <= '0;
         s2_sum1_q  <= '0;
         s2_sum2_q  <= '0;
         s3_valid_q <= 1'b0;
         s3_data_q  <= '0;
`ifdef FPF_CHECK_EN
         s1_err_q   <= 1'b0;
         s2_err_q   <= 1'b0;
         s3_err_q   <= 1'b0;
`endif
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_code_q  <= s1_code_d;
         s2_valid_q <= s2_valid_d;
         s2_sum0_q  <= s2_sum0_d;
         s2_sum1_q  <= s2_sum1_d;
         s2_sum2_q  <= s2_sum2_d;
         s3_valid_q <= s3_valid_d;
         s3_data_q  <= s3_data_d;
`ifdef FPF_CHECK_EN
         s1_err_q   <= s1_err_d;
         s2_err_q   <= s2_err_d;
         s3_err_q   <= s3_err_d;
`endif
      end
   end

   assign out_valid = s3_valid_q;
   assign data_out  = s3_data_q;
`ifdef FPF_CHECK_EN
   assign fpf_err   = s3_err_q;
`endif

endmodule
